// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one 4x4 unsigned multiplier between NUM_REQ requesters.
// Optional macro MULTIPLIER_ARBITER_ZERO_BYPASS_EN: zero operands skip CALC (latency 1).
module multiplier_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NUM_REQ-1:0]     Req_Valid_In,
    input  logic [4*NUM_REQ-1:0]   Req_A_In,
    input  logic [4*NUM_REQ-1:0]   Req_B_In,
    output logic [NUM_REQ-1:0]     Req_Ready_Out,
    output logic                   Result_Valid_Out,
    output logic [7:0]             Result_Data_Out,
    output logic [ID_W-1:0]        Result_Id_Out,
    input  logic                   Result_Ready_In,
    output logic                   Busy_Out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t                r_state;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       r_id;
    logic [3:0]            r_a;
    logic [3:0]            r_b;
    logic [7:0]            r_data;
    logic                  r_valid;
    logic                  r_busy;

    logic                  w_grant_any;
    logic [ID_W-1:0]       w_grant_idx;
    logic [3:0]            w_sel_a;
    logic [3:0]            w_sel_b;
    logic [7:0]            w_product;
    logic [ID_W-1:0]       w_next_ptr;

    // Scan from the round-robin pointer upward, wrapping, for the first valid requester.
    always_comb begin
        logic [ID_W-1:0] v_idx;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        v_idx       = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_grant_any && Req_Valid_In[v_idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = v_idx;
            end else begin
                w_grant_any = w_grant_any;
            end
            if (v_idx == ID_W'(NUM_REQ - 1)) begin
                v_idx = '0;
            end else begin
                v_idx = v_idx + ID_W'(1);
            end
        end
    end

    // Grant is offered only while idle and out of reset; at most one bit set.
    always_comb begin
        if ((r_state == S_IDLE) && !Reset && w_grant_any) begin
            Req_Ready_Out = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant_idx;
        end else begin
            Req_Ready_Out = '0;
        end
    end

    assign w_sel_a    = Req_A_In[{w_grant_idx, 2'b00} +: 4];
    assign w_sel_b    = Req_B_In[{w_grant_idx, 2'b00} +: 4];
    assign w_product  = {4'b0000, r_a} * {4'b0000, r_b};
    assign w_next_ptr = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : (r_id + ID_W'(1));

    // Transaction sequencer: capture on grant, multiply, hold product until accepted.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_a      <= 4'd0;
            r_b      <= 4'd0;
            r_data   <= 8'd0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_a    <= w_sel_a;
                        r_b    <= w_sel_b;
                        r_id   <= w_grant_idx;
                        r_busy <= 1'b1;
`ifdef MULTIPLIER_ARBITER_ZERO_BYPASS_EN
                        if ((w_sel_a == 4'd0) || (w_sel_b == 4'd0)) begin
                            r_data  <= 8'd0;
                            r_valid <= 1'b1;
                            r_state <= S_RESULT;
                        end else begin
                            r_state <= S_CALC;
                        end
`else
                        r_state <= S_CALC;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_data  <= w_product;
                    r_valid <= 1'b1;
                    r_state <= S_RESULT;
                end
                S_RESULT: begin
                    // Pointer advances only when the consumer takes the product.
                    if (Result_Ready_In) begin
                        r_valid  <= 1'b0;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_IDLE;
                    end else begin
                        r_state  <= S_RESULT;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Result_Valid_Out = r_valid;
    assign Result_Data_Out  = r_data;
    assign Result_Id_Out    = r_id;
    assign Busy_Out         = r_busy;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Self-checking bench for multiplier_arbiter: directed scenarios plus randomized traffic
// checked against a queue-free arithmetic model of round-robin grant and product.
module tb_multiplier_arbiter;
    localparam int N = 4;
`ifdef MULTIPLIER_ARBITER_ZERO_BYPASS_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [N-1:0]  Req_Valid_In = '0;
    logic [4*N-1:0] Req_A_In = '0;
    logic [4*N-1:0] Req_B_In = '0;
    logic [N-1:0]  Req_Ready_Out;
    logic          Result_Valid_Out;
    logic [7:0]    Result_Data_Out;
    logic [1:0]    Result_Id_Out;
    logic          Result_Ready_In = 1'b0;
    logic          Busy_Out;

    int checks = 0;
    int failures = 0;
    int exp_ptr = 0;

    multiplier_arbiter #(.NUM_REQ(N)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req_Valid_In(Req_Valid_In), .Req_A_In(Req_A_In), .Req_B_In(Req_B_In),
        .Req_Ready_Out(Req_Ready_Out),
        .Result_Valid_Out(Result_Valid_Out), .Result_Data_Out(Result_Data_Out),
        .Result_Id_Out(Result_Id_Out), .Result_Ready_In(Result_Ready_In),
        .Busy_Out(Busy_Out)
    );

    always #5 Clk = ~Clk;

    // Reference: winner is the valid requester at the smallest forward distance from ptr.
    function automatic int exp_grant(input logic [N-1:0] v, input int ptr);
        int best = -1;
        int bo = N;
        for (int i = 0; i < N; i++) begin
            if (v[i] && (((i - ptr + N) % N) < bo)) begin
                bo = (i - ptr + N) % N;
                best = i;
            end
        end
        return best;
    endfunction

    function automatic int exp_lat(input int a, input int b);
        return (ZB && (a == 0 || b == 0)) ? 1 : 2;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] one = 1;
        return (g < 0) ? '0 : (one << g);
    endfunction

    task automatic set_ops(input int i, input int a, input int b);
        Req_A_In[4*i +: 4] = 4'(a);
        Req_B_In[4*i +: 4] = 4'(b);
    endtask

    task automatic wait_grant(output int g, output bit ok);
        ok = 1'b0;
        g = -1;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge Clk);
            if (Req_Ready_Out != '0) begin
                ok = 1'b1;
                for (int i = 0; i < N; i++) if (Req_Ready_Out[i]) g = i;
            end
        end
    endtask

    task automatic wait_result(output int lat, output bit ok);
        ok = 1'b0;
        lat = 0;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(negedge Clk);
            lat++;
            if (Result_Valid_Out) ok = 1'b1;
        end
    endtask

    task automatic accept();
        Result_Ready_In = 1'b1;
        @(posedge Clk);
        #1;
        Result_Ready_In = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Req_Valid_In = '1;
        repeat (2) @(negedge Clk);
        checks++; if (Req_Ready_Out !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", Req_Ready_Out); end
        checks++; if (Result_Valid_Out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Result_Valid_Out); end
        checks++; if (Result_Data_Out !== 8'd0 || Result_Id_Out !== 2'd0) begin failures++; $display("FAIL reset_data got=%0d/%0d exp=0/0", Result_Data_Out, Result_Id_Out); end
        checks++; if (Busy_Out !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy_Out); end
        Req_Valid_In = '0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        exp_ptr = 0;
    endtask

    task automatic test_single();
        int g, lat; bit ok;
        set_ops(2, 13, 11);
        Req_Valid_In = 4'b0100;
        wait_grant(g, ok);
        checks++; if (!ok || g !== 2) begin failures++; $display("FAIL single_grant got=%0d exp=2", g); end
        checks++; if (Req_Ready_Out !== 4'b0100) begin failures++; $display("FAIL single_onehot got=%b exp=0100", Req_Ready_Out); end
        @(posedge Clk); #1;
        Req_Valid_In = '0;
        @(negedge Clk);
        checks++; if (Busy_Out !== 1'b1 || Req_Ready_Out !== 4'b0000) begin failures++; $display("FAIL single_calc got busy=%b rdy=%b exp busy=1 rdy=0000", Busy_Out, Req_Ready_Out); end
        wait_result(lat, ok);
        checks++; if (!ok || lat + 1 !== 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", lat + 1); end
        checks++; if (Result_Data_Out !== 8'd143 || Result_Id_Out !== 2'd2) begin failures++; $display("FAIL single_result got=%0d/%0d exp=143/2", Result_Data_Out, Result_Id_Out); end
        accept();
        exp_ptr = 3;
    endtask

    task automatic test_round_robin();
        int g, lat, ea, eb; bit ok;
        @(posedge Clk); #1;
        Reset = 1'b1; #2; Reset = 1'b0;
        exp_ptr = 0;
        for (int i = 0; i < N; i++) set_ops(i, $urandom_range(0, 15), $urandom_range(0, 15));
        Result_Ready_In = 1'b1;
        Req_Valid_In = '1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g, ok);
            checks++; if (!ok || g !== exp_grant(4'hF, exp_ptr) || g !== k % N) begin failures++; $display("FAIL rr_order got=%0d exp=%0d", g, k % N); end
            ea = int'(Req_A_In[4*g +: 4]);
            eb = int'(Req_B_In[4*g +: 4]);
            @(posedge Clk); #1;
            set_ops(g, $urandom_range(0, 15), $urandom_range(0, 15));
            wait_result(lat, ok);
            checks++; if (!ok || lat !== exp_lat(ea, eb) || int'(Result_Data_Out) !== ea * eb || int'(Result_Id_Out) !== g) begin
                failures++; $display("FAIL rr_result got lat=%0d data=%0d id=%0d exp lat=%0d data=%0d id=%0d", lat, Result_Data_Out, Result_Id_Out, exp_lat(ea, eb), ea * eb, g);
            end
            exp_ptr = (g + 1) % N;
        end
        Req_Valid_In = '0;
        @(posedge Clk); #1;
        Result_Ready_In = 1'b0;
    endtask

    task automatic test_backpressure();
        int g, lat, r; bit ok;
        r = $urandom_range(0, N - 1);
        set_ops(r, 15, 15);
        Req_Valid_In = onehot(r);
        wait_grant(g, ok);
        checks++; if (!ok || g !== r) begin failures++; $display("FAIL bp_grant got=%0d exp=%0d", g, r); end
        @(posedge Clk); #1;
        Req_Valid_In = '0;
        wait_result(lat, ok);
        checks++; if (!ok || lat !== 2) begin failures++; $display("FAIL bp_latency got=%0d exp=2", lat); end
        @(posedge Clk); #1;
        Req_Valid_In = '1;
        for (int j = 0; j < 10; j++) begin
            @(negedge Clk);
            checks++; if (Result_Valid_Out !== 1'b1 || Result_Data_Out !== 8'd225 || int'(Result_Id_Out) !== r || Req_Ready_Out !== 4'b0000) begin
                failures++; $display("FAIL bp_hold got v=%b d=%0d id=%0d rdy=%b exp v=1 d=225 id=%0d rdy=0000", Result_Valid_Out, Result_Data_Out, Result_Id_Out, Req_Ready_Out, r);
            end
        end
        accept();
        exp_ptr = (r + 1) % N;
        @(negedge Clk);
        checks++; if (Busy_Out !== 1'b0 || Result_Valid_Out !== 1'b0 || Req_Ready_Out !== onehot(exp_grant(4'hF, exp_ptr))) begin
            failures++; $display("FAIL bp_release got busy=%b v=%b rdy=%b exp busy=0 v=0 rdy=%b", Busy_Out, Result_Valid_Out, Req_Ready_Out, onehot(exp_grant(4'hF, exp_ptr)));
        end
        Req_Valid_In = '0;
        @(posedge Clk); #1;
    endtask

    task automatic test_wrap_skip();
        int g, lat; bit ok;
        set_ops(2, 1, 1);
        Req_Valid_In = 4'b0100;
        wait_grant(g, ok);
        @(posedge Clk); #1;
        Req_Valid_In = '0;
        wait_result(lat, ok);
        accept();
        exp_ptr = 3;
        set_ops(1, 7, 9);
        set_ops(3, 5, 12);
        Req_Valid_In = 4'b1010;
        wait_grant(g, ok);
        checks++; if (!ok || g !== 3 || g !== exp_grant(4'b1010, exp_ptr)) begin failures++; $display("FAIL wrap_first got=%0d exp=3", g); end
        @(posedge Clk); #1;
        Req_Valid_In = 4'b0010;
        wait_result(lat, ok);
        checks++; if (!ok || Result_Data_Out !== 8'd60 || Result_Id_Out !== 2'd3) begin failures++; $display("FAIL wrap_res3 got=%0d/%0d exp=60/3", Result_Data_Out, Result_Id_Out); end
        accept();
        exp_ptr = 0;
        wait_grant(g, ok);
        checks++; if (!ok || g !== 1) begin failures++; $display("FAIL wrap_second got=%0d exp=1", g); end
        @(posedge Clk); #1;
        Req_Valid_In = '0;
        wait_result(lat, ok);
        checks++; if (!ok || Result_Data_Out !== 8'd63 || Result_Id_Out !== 2'd1) begin failures++; $display("FAIL wrap_res1 got=%0d/%0d exp=63/1", Result_Data_Out, Result_Id_Out); end
        accept();
        exp_ptr = 2;
    endtask

    task automatic test_zero();
        int g, lat; bit ok;
        for (int t = 0; t < 2; t++) begin
            int a = (t == 0) ? 0 : $urandom_range(1, 15);
            int b = (t == 0) ? 9 : 0;
            set_ops(exp_ptr, a, b);
            Req_Valid_In = onehot(exp_ptr);
            wait_grant(g, ok);
            @(posedge Clk); #1;
            Req_Valid_In = '0;
            wait_result(lat, ok);
            checks++; if (!ok || lat !== exp_lat(a, b) || Result_Data_Out !== 8'd0 || int'(Result_Id_Out) !== g) begin
                failures++; $display("FAIL zero_op got lat=%0d d=%0d exp lat=%0d d=0", lat, Result_Data_Out, exp_lat(a, b));
            end
            accept();
            exp_ptr = (g + 1) % N;
        end
    endtask

    task automatic test_reset_mid();
        int g, lat; bit ok;
        set_ops(exp_ptr, 6, 7);
        Req_Valid_In = onehot(exp_ptr);
        wait_grant(g, ok);
        @(posedge Clk); #1;
        Req_Valid_In = '1;
        Reset = 1'b1;
        #1;
        checks++; if (Busy_Out !== 1'b0 || Result_Valid_Out !== 1'b0 || Result_Data_Out !== 8'd0 || Result_Id_Out !== 2'd0 || Req_Ready_Out !== 4'b0000) begin
            failures++; $display("FAIL mid_reset got busy=%b v=%b d=%0d id=%0d rdy=%b exp all 0", Busy_Out, Result_Valid_Out, Result_Data_Out, Result_Id_Out, Req_Ready_Out);
        end
        Req_Valid_In = '0;
        @(negedge Clk);
        Reset = 1'b0;
        exp_ptr = 0;
        @(posedge Clk); #1;
        for (int i = 0; i < N; i++) set_ops(i, i + 2, 3);
        Req_Valid_In = '1;
        wait_grant(g, ok);
        checks++; if (!ok || g !== 0) begin failures++; $display("FAIL mid_ptr got=%0d exp=0", g); end
        @(posedge Clk); #1;
        Req_Valid_In = '0;
        wait_result(lat, ok);
        checks++; if (!ok || lat !== 2 || Result_Data_Out !== 8'd6) begin failures++; $display("FAIL mid_after got lat=%0d d=%0d exp lat=2 d=6", lat, Result_Data_Out); end
        accept();
        exp_ptr = 1;
    endtask

    task automatic test_random();
        int g, lat, ea, eb, hold, eg; bit ok;
        logic [N-1:0] mask;
        for (int t = 0; t < 40; t++) begin
            mask = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++)
                set_ops(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15), $urandom_range(0, 15));
            Req_Valid_In = mask;
            eg = exp_grant(mask, exp_ptr);
            wait_grant(g, ok);
            checks++; if (!ok || g !== eg || Req_Ready_Out !== onehot(eg)) begin failures++; $display("FAIL rand_grant got=%0d rdy=%b exp=%0d", g, Req_Ready_Out, eg); end
            ea = int'(Req_A_In[4*eg +: 4]);
            eb = int'(Req_B_In[4*eg +: 4]);
            @(posedge Clk); #1;
            Req_Valid_In = '0;
            wait_result(lat, ok);
            checks++; if (!ok || lat !== exp_lat(ea, eb) || int'(Result_Data_Out) !== ea * eb || int'(Result_Id_Out) !== eg) begin
                failures++; $display("FAIL rand_result got lat=%0d d=%0d id=%0d exp lat=%0d d=%0d id=%0d", lat, Result_Data_Out, Result_Id_Out, exp_lat(ea, eb), ea * eb, eg);
            end
            hold = $urandom_range(0, 3);
            for (int j = 0; j < hold; j++) begin
                @(negedge Clk);
                checks++; if (Result_Valid_Out !== 1'b1 || int'(Result_Data_Out) !== ea * eb) begin failures++; $display("FAIL rand_hold got v=%b d=%0d exp v=1 d=%0d", Result_Valid_Out, Result_Data_Out, ea * eb); end
            end
            accept();
            exp_ptr = (eg + 1) % N;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_zero();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
